// File: rtl/apb_reg_bank_pkg.sv
// Shared types and decode helpers for the APB register bank.
package apb_reg_bank_pkg;

  // Kept as plain constants so older tools that dislike enum FSM state compare cleanly.
  typedef logic state_e;
  localparam state_e IDLE   = 1'b0;
  localparam state_e ACCESS = 1'b1;

  typedef enum logic [1:0] {ACC_RW, ACC_RO, ACC_W1C} access_e;

  // Word index from a byte address; the two low address bits are ignored.
  function automatic logic [63:0] addr_to_idx(input logic [63:0] addr);
    return addr >> 2;
  endfunction

  function automatic access_e acc_type(input int unsigned i, input logic [63:0] ro_mask,
                                       input logic [63:0] w1c_mask);
    if (ro_mask[i[5:0]]) return ACC_RO;
    if (w1c_mask[i[5:0]]) return ACC_W1C;
    return ACC_RW;
  endfunction

endpackage

// File: rtl/apb_reg_cell.sv
// One storage register: per-byte writes (RW) or write-1-to-clear with hardware set (W1C).
module apb_reg_cell #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter bit          IS_W1C     = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_WIDTH/8-1:0] byte_we,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH-1:0]   clr,
  input  logic [DATA_WIDTH-1:0]   hw_set,
  output logic [DATA_WIDTH-1:0]   q
);

  logic [DATA_WIDTH-1:0] reg_q, reg_d;

  always_comb begin
    reg_d = reg_q;
    if (IS_W1C) begin
      // Set is applied after clear so a coincident hardware event is never lost.
      reg_d = (reg_q & ~clr) | hw_set;
    end else begin
      for (int unsigned b = 0; b < DATA_WIDTH / 8; b++) begin
        if (byte_we[b]) reg_d[b*8 +: 8] = wdata[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) reg_q <= '0;
    else        reg_q <= reg_d;
  end

  assign q = reg_q;

endmodule

// File: rtl/apb_reg_bank.sv
// APB3 slave register bank with RW / RO / W1C registers, byte strobes and wait states.
// Define APB_REG_BANK_LOCK_EN to add a sticky write-lock register at index NUM_REGS.
module apb_reg_bank
  import apb_reg_bank_pkg::*;
#(
  parameter int unsigned         DATA_WIDTH  = 32,
  parameter int unsigned         NUM_REGS    = 8,
  parameter int unsigned         ADDR_WIDTH  = 12,
  parameter int unsigned         WAIT_STATES = 0,
  parameter logic [NUM_REGS-1:0] RO_MASK     = '0,
  parameter logic [NUM_REGS-1:0] W1C_MASK    = '0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           psel,
  input  logic                           penable,
  input  logic                           pwrite,
  input  logic [ADDR_WIDTH-1:0]          paddr,
  input  logic [DATA_WIDTH-1:0]          pwdata,
  input  logic [DATA_WIDTH/8-1:0]        pstrb,
  output logic [DATA_WIDTH-1:0]          prdata,
  output logic                           pready,
  output logic                           pslverr,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_in,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out
);

  localparam int unsigned NB = DATA_WIDTH / 8;

  if ((RO_MASK & W1C_MASK) != '0) begin : gen_mask_check
    $error("apb_reg_bank: RO_MASK and W1C_MASK overlap");
  end
  if ((64'(1) << (ADDR_WIDTH - 2)) <= 64'(NUM_REGS)) begin : gen_addr_check
    $error("apb_reg_bank: ADDR_WIDTH too small for NUM_REGS");
  end

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [63:0]           idx;
  logic                  in_range, sel_ro, err, wr_commit;
  access_e               sel_acc;
  logic [DATA_WIDTH-1:0] rd_val, rd_mux, strb_mask;

  assign idx      = addr_to_idx(64'(paddr));
  assign in_range = idx < 64'(NUM_REGS);
  assign pready   = (state_q == ACCESS) & psel & penable & (cnt_q == 4'(WAIT_STATES));

  always_comb begin
    sel_acc = ACC_RW;
    rd_val  = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (idx == 64'(i)) begin
        sel_acc = acc_type(i, 64'(RO_MASK), 64'(W1C_MASK));
        rd_val  = (sel_acc == ACC_RO) ? hw_in[i*DATA_WIDTH +: DATA_WIDTH]
                                      : reg_out[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign sel_ro = in_range & (sel_acc == ACC_RO);

  always_comb begin
    strb_mask = '0;
    for (int unsigned b = 0; b < NB; b++) strb_mask[b*8 +: 8] = {8{pstrb[b]}};
  end

`ifdef APB_REG_BANK_LOCK_EN
  logic lock_q, is_lock;

  assign is_lock = idx == 64'(NUM_REGS);
  // Only RW registers are frozen by the lock; W1C status can still be acknowledged.
  assign err     = (!in_range & !is_lock) | (pwrite & sel_ro) |
                   (pwrite & lock_q & in_range & (sel_acc == ACC_RW));
  assign rd_mux  = is_lock ? DATA_WIDTH'(lock_q) : rd_val;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lock_q <= 1'b0;
    else        lock_q <= lock_q | (wr_commit & is_lock & pstrb[0] & pwdata[0]);
  end
`else
  assign err    = !in_range | (pwrite & sel_ro);
  assign rd_mux = rd_val;
`endif

  assign pslverr   = pready & err;
  assign wr_commit = pready & pwrite & !err;
  assign prdata    = (pready & !pwrite & !err) ? rd_mux : '0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (psel & !penable) state_d = ACCESS;
      end
      ACCESS: begin
        if (pready | !psel) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (penable) begin
          cnt_d = cnt_q + 4'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : gen_reg
    localparam access_e Acc = acc_type(i, 64'(RO_MASK), 64'(W1C_MASK));

    if (Acc == ACC_RO) begin : gen_ro
      assign reg_out[i*DATA_WIDTH +: DATA_WIDTH] = '0;
    end else begin : gen_cell
      logic hit;
      assign hit = wr_commit & (idx == 64'(i));

      apb_reg_cell #(
        .DATA_WIDTH (DATA_WIDTH),
        .IS_W1C     (Acc == ACC_W1C)
      ) u_cell (
        .clk     (clk),
        .rst_n   (rst_n),
        .byte_we (pstrb & {NB{hit}}),
        .wdata   (pwdata),
        .clr     (pwdata & strb_mask & {DATA_WIDTH{hit}}),
        .hw_set  ((Acc == ACC_W1C) ? hw_in[i*DATA_WIDTH +: DATA_WIDTH] : '0),
        .q       (reg_out[i*DATA_WIDTH +: DATA_WIDTH])
      );
    end
  end

endmodule

// File: tb/tb_apb_reg_bank.sv
// Directed bench for apb_reg_bank: two instances (0 and 3 wait states) and a read/response scoreboard.
module tb_apb_reg_bank;

  localparam int DW = 32;
  localparam int NR = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          psel, penable, pwrite, tgt;
  logic [11:0]   paddr;
  logic [DW-1:0] pwdata;
  logic [3:0]    pstrb;
  logic [NR*DW-1:0] hw_in;

  logic [DW-1:0]    prdata0, prdata1;
  logic             pready0, pready1, pslverr0, pslverr1;
  logic [NR*DW-1:0] reg_out0, reg_out1;
  logic             psel0, psel1, cur_pready, cur_pslverr;
  logic [DW-1:0]    cur_prdata;

  assign psel0       = psel & !tgt;
  assign psel1       = psel & tgt;
  assign cur_pready  = tgt ? pready1 : pready0;
  assign cur_pslverr = tgt ? pslverr1 : pslverr0;
  assign cur_prdata  = tgt ? prdata1 : prdata0;

  always #5 clk = ~clk;

  apb_reg_bank #(
    .DATA_WIDTH (DW), .NUM_REGS (NR), .ADDR_WIDTH (12), .WAIT_STATES (0),
    .RO_MASK (8'h02), .W1C_MASK (8'h08)
  ) dut (
    .clk (clk), .rst_n (rst_n), .psel (psel0), .penable (penable), .pwrite (pwrite),
    .paddr (paddr), .pwdata (pwdata), .pstrb (pstrb), .prdata (prdata0),
    .pready (pready0), .pslverr (pslverr0), .hw_in (hw_in), .reg_out (reg_out0)
  );

  apb_reg_bank #(
    .DATA_WIDTH (DW), .NUM_REGS (NR), .ADDR_WIDTH (12), .WAIT_STATES (3),
    .RO_MASK (8'h02), .W1C_MASK (8'h08)
  ) dut_ws (
    .clk (clk), .rst_n (rst_n), .psel (psel1), .penable (penable), .pwrite (pwrite),
    .paddr (paddr), .pwdata (pwdata), .pstrb (pstrb), .prdata (prdata1),
    .pready (pready1), .pslverr (pslverr1), .hw_in (hw_in), .reg_out (reg_out1)
  );

  typedef struct packed {
    logic [DW-1:0] rd;
    logic          err;
  } exp_t;

  exp_t          sb_q[$];
  int            checks = 0;
  int            errors = 0;
  logic [NR*DW-1:0] exp_regs;

  task automatic check(input string tag, input logic [NR*DW-1:0] obs,
                       input logic [NR*DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Starts at posedge+1 and returns at posedge+1 after the completing edge.
  task automatic apb_xfer(input logic t, input logic wr, input logic [11:0] addr,
                          input logic [DW-1:0] wd, input logic [3:0] st,
                          input logic [DW-1:0] exp_rd, input logic exp_err, input string tag);
    int   waits;
    logic done;
    exp_t e;
    sb_q.push_back(exp_t'{rd: exp_rd, err: exp_err});
    tgt = t; psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd; pstrb = st;
    @(posedge clk); #1 penable = 1'b1;
    waits = 0;
    done  = 1'b0;
    while (!done && waits < 40) begin
      @(negedge clk);
      waits++;
      if (cur_pready === 1'b1) begin
        e = sb_q.pop_front();
        check({tag, "_rdata"}, NR*DW'(cur_prdata), NR*DW'(e.rd));
        check({tag, "_err"}, NR*DW'(cur_pslverr), NR*DW'(e.err));
        check({tag, "_lat"}, NR*DW'(waits), NR*DW'(t ? 4 : 1));
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    check({tag, "_done"}, NR*DW'(done), NR*DW'(1));
    if (!done) void'(sb_q.pop_front());
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic abort_write(input logic t, input logic [11:0] addr, input logic [DW-1:0] wd,
                             input int n_access);
    tgt = t; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = addr; pwdata = wd;
    pstrb = 4'hF;
    @(posedge clk); #1 penable = 1'b1;
    for (int k = 0; k < n_access; k++) begin
      @(negedge clk);
      check($sformatf("abort_pready_%0d", k), NR*DW'(cur_pready), '0);
      @(posedge clk); #1;
    end
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; tgt = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0; hw_in = '0;
    repeat (3) @(posedge clk);
    #1 psel = 1'b1; penable = 1'b1;
    @(negedge clk);
    check("rst_pready", NR*DW'(pready0), '0);
    check("rst_pslverr", NR*DW'(pslverr0), '0);
    check("rst_prdata", NR*DW'(prdata0), '0);
    check("rst_reg_out", reg_out0, '0);
    check("rst_pready_ws", NR*DW'(pready1), '0);
    psel = 1'b0; penable = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < NR; i++)
      apb_xfer(0, 0, 12'(i * 4), '0, '0, '0, 1'b0, $sformatf("rd_reset_%0d", i));

    // RW with partial strobes
    apb_xfer(0, 1, 12'h008, 32'h1122_3344, 4'hF, '0, 1'b0, "wr_idx2_init");
    apb_xfer(0, 1, 12'h008, 32'hDEAD_BEEF, 4'b0101, '0, 1'b0, "wr_idx2_strb");
    apb_xfer(0, 0, 12'h008, '0, '0, 32'h11AD_33EF, 1'b0, "rd_idx2");
    check("reg_out_idx2", NR*DW'(reg_out0[2*DW +: DW]), NR*DW'(32'h11AD_33EF));
    apb_xfer(0, 1, 12'h008, 32'hFFFF_FFFF, 4'h0, '0, 1'b0, "wr_idx2_nostrb");
    apb_xfer(0, 0, 12'h008, '0, '0, 32'h11AD_33EF, 1'b0, "rd_idx2_nostrb");

    // W1C: hardware set pulse, clear, and coincident set/clear
    hw_in[3*DW +: DW] = 32'h0000_00F0;
    @(posedge clk); #1 hw_in[3*DW +: DW] = '0;
    apb_xfer(0, 0, 12'h00C, '0, '0, 32'h0000_00F0, 1'b0, "rd_w1c_set");
    apb_xfer(0, 1, 12'h00C, 32'h0000_0030, 4'hF, '0, 1'b0, "wr_w1c_clr");
    apb_xfer(0, 0, 12'h00C, '0, '0, 32'h0000_00C0, 1'b0, "rd_w1c_clr");
    hw_in[3*DW +: DW] = 32'h0000_0080;
    apb_xfer(0, 1, 12'h00C, 32'h0000_0080, 4'hF, '0, 1'b0, "wr_w1c_race");
    hw_in[3*DW +: DW] = '0;
    apb_xfer(0, 0, 12'h00C, '0, '0, 32'h0000_00C0, 1'b0, "rd_w1c_race");
    apb_xfer(0, 1, 12'h00C, 32'h0000_0040, 4'hE, '0, 1'b0, "wr_w1c_unstrobed");
    apb_xfer(0, 0, 12'h00C, '0, '0, 32'h0000_00C0, 1'b0, "rd_w1c_unstrobed");
    apb_xfer(0, 1, 12'h00C, 32'h0000_0040, 4'h1, '0, 1'b0, "wr_w1c_bit6");
    apb_xfer(0, 0, 12'h00C, '0, '0, 32'h0000_0080, 1'b0, "rd_w1c_bit6");

    // RO live read, errored writes, out-of-range index
    hw_in[1*DW +: DW] = 32'hCAFE_F00D;
    apb_xfer(0, 0, 12'h004, '0, '0, 32'hCAFE_F00D, 1'b0, "rd_ro");
    apb_xfer(0, 1, 12'h004, 32'h1234_5678, 4'hF, '0, 1'b1, "wr_ro_err");
    apb_xfer(0, 1, 12'h040, 32'h1234_5678, 4'hF, '0, 1'b1, "wr_oor_err");
    apb_xfer(0, 0, 12'h040, '0, '0, '0, 1'b1, "rd_oor_err");
    apb_xfer(0, 1, 12'h013, 32'h1234_5678, 4'hF, '0, 1'b0, "wr_idx4_lowbits");
    apb_xfer(0, 0, 12'h010, '0, '0, 32'h1234_5678, 1'b0, "rd_idx4");
    exp_regs = '0;
    exp_regs[2*DW +: DW] = 32'h11AD_33EF;
    exp_regs[3*DW +: DW] = 32'h0000_0080;
    exp_regs[4*DW +: DW] = 32'h1234_5678;
    check("reg_out_all", reg_out0, exp_regs);

`ifdef APB_REG_BANK_LOCK_EN
    apb_xfer(0, 0, 12'h020, '0, '0, '0, 1'b0, "rd_lock_init");
    apb_xfer(0, 1, 12'h020, 32'h0000_0001, 4'h1, '0, 1'b0, "wr_lock");
    apb_xfer(0, 0, 12'h020, '0, '0, 32'h0000_0001, 1'b0, "rd_lock_set");
    apb_xfer(0, 1, 12'h000, 32'h0000_FFFF, 4'hF, '0, 1'b1, "wr_locked_rw");
    apb_xfer(0, 0, 12'h000, '0, '0, '0, 1'b0, "rd_locked_rw");
    apb_xfer(0, 1, 12'h00C, 32'h0000_0080, 4'hF, '0, 1'b0, "wr_locked_w1c");
    apb_xfer(0, 0, 12'h00C, '0, '0, '0, 1'b0, "rd_locked_w1c");
`else
    apb_xfer(0, 1, 12'h020, 32'h0000_0001, 4'hF, '0, 1'b1, "wr_idx8_err");
    apb_xfer(0, 0, 12'h020, '0, '0, '0, 1'b1, "rd_idx8_err");
`endif

    // Wait states and abort on the second instance
    apb_xfer(1, 1, 12'h000, 32'hA5A5_A5A5, 4'hF, '0, 1'b0, "ws_wr");
    apb_xfer(1, 0, 12'h000, '0, '0, 32'hA5A5_A5A5, 1'b0, "ws_rd");
    abort_write(1, 12'h000, 32'h0000_0000, 2);
    check("ws_abort_reg_out", NR*DW'(reg_out1[0 +: DW]), NR*DW'(32'hA5A5_A5A5));
    apb_xfer(1, 0, 12'h000, '0, '0, 32'hA5A5_A5A5, 1'b0, "ws_rd_after_abort");

    // Asynchronous reset in the middle of a write
    tgt = 1'b1; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h000;
    pwdata = 32'h0000_0000; pstrb = 4'hF;
    @(posedge clk); #1 penable = 1'b1;
    @(negedge clk);
    check("midrst_pready_pre", NR*DW'(pready1), '0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_reg_out_ws", reg_out1, '0);
    check("midrst_reg_out", reg_out0, '0);
    check("midrst_pready", NR*DW'(pready1), '0);
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    apb_xfer(1, 0, 12'h000, '0, '0, '0, 1'b0, "postrst_ws_rd");
    apb_xfer(0, 0, 12'h008, '0, '0, '0, 1'b0, "postrst_rd_idx2");
`ifdef APB_REG_BANK_LOCK_EN
    apb_xfer(0, 0, 12'h020, '0, '0, '0, 1'b0, "postrst_rd_lock");
    apb_xfer(0, 1, 12'h000, 32'h0000_0077, 4'hF, '0, 1'b0, "postrst_wr_unlocked");
    apb_xfer(0, 0, 12'h000, '0, '0, 32'h0000_0077, 1'b0, "postrst_rd_unlocked");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_reg_bank.md
Name: apb_reg_bank

Overview:
- Parametrised APB3 slave register bank; successor to the single enable-gated register cell.
- Holds NUM_REGS registers of DATA_WIDTH bits. Each register is RW, RO (hardware-driven) or W1C (hardware-set status).
- Supports byte strobes, configurable wait states and error response.
- Sits between the APB interconnect and the timer core: control outputs to the core, status/counter inputs from it.

Parameters:
- DATA_WIDTH, 32, register/bus width; multiple of 8, 8..64.
- NUM_REGS, 8, number of registers, 1..64.
- ADDR_WIDTH, 12, paddr width; must satisfy 2^(ADDR_WIDTH-2) > NUM_REGS.
- WAIT_STATES, 0, access-phase cycles before pready, 0..15.
- RO_MASK, '0, NUM_REGS bits; bit i=1 -> register i is RO.
- W1C_MASK, '0, NUM_REGS bits; bit i=1 -> register i is W1C. RO_MASK & W1C_MASK must be 0 (elaboration assertion).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- psel  in  1  APB select
- penable  in  1  APB access phase
- pwrite  in  1  1=write, 0=read
- paddr  in  ADDR_WIDTH  byte address
- pwdata  in  DATA_WIDTH  write data
- pstrb  in  DATA_WIDTH/8  byte-lane write strobes
- prdata  out  DATA_WIDTH  read data
- pready  out  1  transfer complete
- pslverr  out  1  error response, valid with pready
- hw_in  in  NUM_REGS*DATA_WIDTH  per register, slice i: RO -> read value; W1C -> per-bit set pulses; RW -> ignored
- reg_out  out  NUM_REGS*DATA_WIDTH  current stored value per register; RO slices tied 0

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset: all stored registers 0, wait counter 0, reg_out 0. prdata, pready and pslverr read 0 while rst_n=0.
- Decode: idx = paddr[ADDR_WIDTH-1:2]; paddr[1:0] ignored.
- FSM IDLE/ACCESS:
  - IDLE -> ACCESS on psel&!penable (setup).
  - ACCESS -> IDLE when pready=1 or psel=0 (abort).
- Wait counter cnt: cleared in IDLE; increments each ACCESS cycle with psel&penable&!pready.
- pready = (state==ACCESS)&psel&penable&(cnt==WAIT_STATES). With WAIT_STATES=0, setup+1 access cycle (2 cycles total).
- Error: pslverr=pready&(idx>=NUM_REGS | (pwrite & RO_MASK[idx])). An errored write updates nothing; an errored read returns prdata=0.
- Write commit: on the clock edge where pready&pwrite&!pslverr.
  - RW: byte lane b <= pwdata lane b where pstrb[b]=1; other lanes hold.
  - W1C: bit cleared where pwdata=1 within a strobed lane.
  - pstrb=0 gives an OK response with no change.
- W1C set: every cycle, bit |= hw_in bit. On the same cycle as a clear of that bit, the set wins (bit stays 1).
- Read: prdata = RW/W1C stored value or RO live hw_in slice when pready&!pwrite; else 0. Reads have no side effects.
- Abort: psel dropped before pready -> no write, cnt cleared, return to IDLE.
- Back-to-back: a new setup is accepted on the cycle after pready.
- Async reset mid-transfer: FSM returns to IDLE immediately; the transfer is lost with no write.

Optional Feature:
- Macro APB_REG_BANK_LOCK_EN.
- Defined:
  - Extra LOCK register at idx=NUM_REGS.
  - Writing 1 to bit0 sets a sticky lock; it clears only on reset. Reads return {0..,lock}.
  - While locked, writes to RW registers give pslverr=1 and no update. W1C clears stay allowed.
- Undefined: idx=NUM_REGS is out of range -> pslverr. No lock logic.

Decomposition:
- Package apb_reg_bank_pkg:
  - state_e {IDLE, ACCESS}.
  - access_e {ACC_RW, ACC_RO, ACC_W1C}.
  - Function addr_to_idx.
  - Function acc_type(i, RO_MASK, W1C_MASK).
- Sub-module apb_reg_cell: one register with async reset, per-byte write enables, W1C clear mask and hw set; instantiated NUM_REGS times via generate, RO slots omitted.

Test Plan:
- Reset, then read idx0..7 with WAIT_STATES=0 -> prdata=0, pready in 2nd cycle, pslverr=0.
- Write 0xDEADBEEF, pstrb=4'b0101, to RW idx2 holding 0x11223344 -> read 0x11AD33EF; reg_out slice 2 matches.
- W1C idx3: hw_in pulse 0x0000_00F0 -> read 0xF0; write 0x30 -> read 0xC0. Clear 0x80 with same-cycle hw set 0x80 -> bit7 stays 1.
- WAIT_STATES=3: read -> pready after exactly 4 access cycles. Drop psel after 2 access cycles on a write -> no update, next transfer normal.
- Write RO idx1 or paddr=0x40 (idx16) -> pslverr=1 with pready, no register changes; read idx16 -> prdata=0, pslverr=1.
- LOCK_EN: write 1 to idx NUM_REGS, then write RW idx0 -> pslverr=1, value unchanged; assert rst_n=0 mid-write -> lock and all registers 0.
